// File: rtl/ram_arbiter_if.sv
// Requester / RAM-side bundle of the two-port RAM arbiter.
// slave  : the arbiter's view (takes commands and read data, drives grants and the RAM).
// master : the environment's view (requesters plus the RAM instance).
interface ram_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  // requester A
  logic          req_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a;
  logic          gnt_a;
  logic          rvalid_a;
  logic [DW-1:0] rdata_a;
  // requester B
  logic          req_b;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;
  logic          gnt_b;
  logic          rvalid_b;
  logic [DW-1:0] rdata_b;
  // RAM side
  logic          ram_wr_en;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data;
  // status
  logic          init_done;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  ram_rd_data,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b,
    output ram_wr_en, ram_rd_en, ram_addr, ram_wr_data,
    output init_done
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output ram_rd_data,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b,
    input  ram_wr_en, ram_rd_en, ram_addr, ram_wr_data,
    input  init_done
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between
// requesters A and B. Optionally fills the RAM with INIT_VAL after reset.
// All outputs are registered; a grant decided in cycle N shows in N+1.
module ram_arbiter #(
  parameter int              AW       = 5,
  parameter int              DW       = 8,
  parameter int              RD_LAT   = 1,
  parameter int              INIT_EN  = 1,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  localparam state_t ST_RESET = (INIT_EN != 0) ? ST_INIT : ST_RUN;

  state_t        state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic          last_b_q, last_b_d;     // 1 = B won the last grant
  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic          wr_en_q, wr_en_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          init_done_q;
  logic          rvalid_a_q, rvalid_b_q;
  logic [DW-1:0] rdata_a_q, rdata_b_q;
  // bit k set = a read for that requester was granted k cycles ago
  logic [RD_LAT:0] rd_pipe_a_q, rd_pipe_b_q;

  logic eff_a, eff_b, pick_a, pick_b;

  // A requester whose grant is currently showing is masked, so a held
  // command is never served twice; ties go to whoever did not win last.
  always_comb begin
    eff_a  = bus.req_a & ~gnt_a_q;
    eff_b  = bus.req_b & ~gnt_b_q;
    pick_a = eff_a & (~eff_b | last_b_q);
    pick_b = eff_b & ~pick_a;
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= ST_RESET;
    else         state_q <= state_d;
  end

  // Next state: leave INIT after the write to the last address
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_cnt_q == {AW{1'b1}}) state_d = ST_RUN;
  end

  // Output decode: clear sweep in INIT, winner's command in RUN
  always_comb begin
    init_cnt_d = init_cnt_q;
    last_b_d   = last_b_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_INIT: begin
        wr_en_d    = 1'b1;
        addr_d     = init_cnt_q;
        wdata_d    = INIT_VAL;
        init_cnt_d = init_cnt_q + 1'b1;
      end
      default: begin
        if (pick_a) begin
          gnt_a_d  = 1'b1;
          wr_en_d  = bus.we_a;
          rd_en_d  = ~bus.we_a;
          addr_d   = bus.addr_a;
          wdata_d  = bus.wdata_a;
          last_b_d = 1'b0;
        end else if (pick_b) begin
          gnt_b_d  = 1'b1;
          wr_en_d  = bus.we_b;
          rd_en_d  = ~bus.we_b;
          addr_d   = bus.addr_b;
          wdata_d  = bus.wdata_b;
          last_b_d = 1'b1;
        end
      end
    endcase
  end

  // Output registers, read-tag pipelines and read-data capture
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      init_cnt_q  <= '0;
      last_b_q    <= 1'b1;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
      rd_pipe_a_q <= '0;
      rd_pipe_b_q <= '0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      last_b_q    <= last_b_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      // lags the state by one cycle so it rises after the last clear write
      init_done_q <= (state_q == ST_RUN);
      rd_pipe_a_q <= {rd_pipe_a_q[RD_LAT-1:0], gnt_a_d & rd_en_d};
      rd_pipe_b_q <= {rd_pipe_b_q[RD_LAT-1:0], gnt_b_d & rd_en_d};
      // RAM data is valid in the cycle the tag reaches the top stage
      rvalid_a_q  <= rd_pipe_a_q[RD_LAT];
      rvalid_b_q  <= rd_pipe_b_q[RD_LAT];
      if (rd_pipe_a_q[RD_LAT]) rdata_a_q <= bus.ram_rd_data;
      if (rd_pipe_b_q[RD_LAT]) rdata_b_q <= bus.ram_rd_data;
    end
  end

  assign bus.gnt_a       = gnt_a_q;
  assign bus.gnt_b       = gnt_b_q;
  assign bus.rvalid_a    = rvalid_a_q;
  assign bus.rvalid_b    = rvalid_b_q;
  assign bus.rdata_a     = rdata_a_q;
  assign bus.rdata_b     = rdata_b_q;
  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_rd_en   = rd_en_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wr_data = wdata_q;
  assign bus.init_done   = init_done_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: dut1 (RD_LAT=1, INIT_EN=1) runs a per-cycle
// vector table plus reset/INIT sequences; dut2 (RD_LAT=2, INIT_EN=0) checks
// the longer read latency.
module tb_ram_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk  = 1'b0;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
  ram_arbiter_if #(.AW(AW), .DW(DW)) bus2 ();

  ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .INIT_EN(1), .INIT_VAL(8'h00))
    u_dut1 (.sys_clk(clk), .sys_rst(rst1), .bus(bus1));
  ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2), .INIT_EN(0), .INIT_VAL(8'h00))
    u_dut2 (.sys_clk(clk), .sys_rst(rst2), .bus(bus2));

  // RAM models: registered read, RD_LAT cycles after the sampling edge
  logic [DW-1:0] mem1 [32];
  logic [DW-1:0] rp1;
  logic [DW-1:0] mem2 [32];
  logic [DW-1:0] rp2_0, rp2_1;

  always @(posedge clk) begin
    if (bus1.ram_wr_en) mem1[bus1.ram_addr] <= bus1.ram_wr_data;
    if (bus1.ram_rd_en) rp1 <= mem1[bus1.ram_addr];
  end
  always @(posedge clk) begin
    if (bus2.ram_wr_en) mem2[bus2.ram_addr] <= bus2.ram_wr_data;
    if (bus2.ram_rd_en) rp2_0 <= mem2[bus2.ram_addr];
    rp2_1 <= rp2_0;
  end
  assign bus1.ram_rd_data = rp1;
  assign bus2.ram_rd_data = rp2_1;

  typedef struct {
    logic ra; logic wa; logic [4:0] aa; logic [7:0] da;
    logic rb; logic wb; logic [4:0] ab; logic [7:0] db;
    logic ga; logic gb; logic wr; logic rd; logic [4:0] ad; logic [7:0] wd;
    logic va; logic vb; logic [7:0] rda; logic [7:0] rdb;
  } vec_t;

  vec_t tbl [18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic ga, input logic gb, input logic wr,
                      input logic rd, input logic [4:0] ad, input logic [7:0] wd,
                      input logic va, input logic vb, input logic [7:0] da,
                      input logic [7:0] db, input logic idn);
    chk({tag, ".gnt_a"},     32'(bus1.gnt_a),       32'(ga));
    chk({tag, ".gnt_b"},     32'(bus1.gnt_b),       32'(gb));
    chk({tag, ".wr_en"},     32'(bus1.ram_wr_en),   32'(wr));
    chk({tag, ".rd_en"},     32'(bus1.ram_rd_en),   32'(rd));
    chk({tag, ".addr"},      32'(bus1.ram_addr),    32'(ad));
    chk({tag, ".wdata"},     32'(bus1.ram_wr_data), 32'(wd));
    chk({tag, ".rvalid_a"},  32'(bus1.rvalid_a),    32'(va));
    chk({tag, ".rvalid_b"},  32'(bus1.rvalid_b),    32'(vb));
    chk({tag, ".rdata_a"},   32'(bus1.rdata_a),     32'(da));
    chk({tag, ".rdata_b"},   32'(bus1.rdata_b),     32'(db));
    chk({tag, ".init_done"}, 32'(bus1.init_done),   32'(idn));
  endtask

  task automatic drive_a(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
    bus1.req_a = r; bus1.we_a = w; bus1.addr_a = a; bus1.wdata_a = d;
  endtask

  task automatic drive_b(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
    bus1.req_b = r; bus1.we_b = w; bus1.addr_b = a; bus1.wdata_b = d;
  endtask

  // Expects the first clear write in the current cycle; leaves both
  // requesters reading (aa / ab) from late INIT so they are pending at RUN.
  task automatic run_init1(input string tag, input logic [4:0] aa, input logic [4:0] ab);
    for (int k = 0; k < 32; k++) begin
      chk1($sformatf("%s.c%0d", tag, k), 1'b0, 1'b0, 1'b1, 1'b0, 5'(k), 8'h00,
           1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      if (k >= 28) begin
        drive_a(1'b1, 1'b0, aa, 8'h00);
        drive_b(1'b1, 1'b0, ab, 8'h00);
      end
      step();
    end
  endtask

  initial begin
    //            A: req we addr  wdata    B: req we addr  wdata    exp: ga gb wr rd addr  wdata   va vb rdata_a rdata_b
    tbl[0]  = '{1'b1,1'b0,5'd3,8'h00, 1'b1,1'b0,5'd7,8'h00, 1'b1,1'b0,1'b0,1'b1,5'd3,8'h00, 1'b0,1'b0,8'h00,8'h00};
    tbl[1]  = '{1'b1,1'b0,5'd3,8'h00, 1'b1,1'b0,5'd7,8'h00, 1'b0,1'b1,1'b0,1'b1,5'd7,8'h00, 1'b0,1'b0,8'h00,8'h00};
    tbl[2]  = '{1'b0,1'b0,5'd3,8'h00, 1'b1,1'b0,5'd7,8'h00, 1'b1,1'b0,1'b0,1'b1,5'd3,8'h00, 1'b1,1'b0,8'h00,8'h00};
    tbl[3]  = '{1'b0,1'b0,5'd3,8'h00, 1'b0,1'b0,5'd7,8'h00, 1'b0,1'b1,1'b0,1'b1,5'd7,8'h00, 1'b0,1'b1,8'h00,8'h00};
    tbl[4]  = '{1'b1,1'b1,5'd5,8'hA5, 1'b0,1'b0,5'd7,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd7,8'h00, 1'b1,1'b0,8'h00,8'h00};
    tbl[5]  = '{1'b1,1'b1,5'd5,8'hA5, 1'b0,1'b0,5'd7,8'h00, 1'b1,1'b0,1'b1,1'b0,5'd5,8'hA5, 1'b0,1'b1,8'h00,8'h00};
    tbl[6]  = '{1'b1,1'b0,5'd5,8'hA5, 1'b0,1'b0,5'd7,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd5,8'hA5, 1'b0,1'b0,8'h00,8'h00};
    tbl[7]  = '{1'b1,1'b0,5'd5,8'hA5, 1'b0,1'b0,5'd7,8'h00, 1'b1,1'b0,1'b0,1'b1,5'd5,8'hA5, 1'b0,1'b0,8'h00,8'h00};
    tbl[8]  = '{1'b0,1'b0,5'd5,8'hA5, 1'b0,1'b0,5'd7,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd5,8'hA5, 1'b0,1'b0,8'h00,8'h00};
    tbl[9]  = '{1'b0,1'b0,5'd5,8'hA5, 1'b1,1'b0,5'd5,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd5,8'hA5, 1'b1,1'b0,8'hA5,8'h00};
    tbl[10] = '{1'b0,1'b0,5'd5,8'hA5, 1'b1,1'b0,5'd5,8'h00, 1'b0,1'b1,1'b0,1'b1,5'd5,8'h00, 1'b0,1'b0,8'hA5,8'h00};
    tbl[11] = '{1'b0,1'b0,5'd5,8'hA5, 1'b1,1'b0,5'd5,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd5,8'h00, 1'b0,1'b0,8'hA5,8'h00};
    tbl[12] = '{1'b0,1'b0,5'd5,8'hA5, 1'b1,1'b0,5'd5,8'h00, 1'b0,1'b1,1'b0,1'b1,5'd5,8'h00, 1'b0,1'b1,8'hA5,8'hA5};
    tbl[13] = '{1'b0,1'b0,5'd5,8'hA5, 1'b1,1'b0,5'd5,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd5,8'h00, 1'b0,1'b0,8'hA5,8'hA5};
    tbl[14] = '{1'b0,1'b0,5'd5,8'hA5, 1'b1,1'b0,5'd5,8'h00, 1'b0,1'b1,1'b0,1'b1,5'd5,8'h00, 1'b0,1'b1,8'hA5,8'hA5};
    tbl[15] = '{1'b0,1'b0,5'd5,8'hA5, 1'b0,1'b0,5'd5,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd5,8'h00, 1'b0,1'b0,8'hA5,8'hA5};
    tbl[16] = '{1'b0,1'b0,5'd5,8'hA5, 1'b0,1'b0,5'd5,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd5,8'h00, 1'b0,1'b1,8'hA5,8'hA5};
    tbl[17] = '{1'b1,1'b0,5'd5,8'h00, 1'b0,1'b0,5'd5,8'h00, 1'b0,1'b0,1'b0,1'b0,5'd5,8'h00, 1'b0,1'b0,8'hA5,8'hA5};

    drive_a(1'b0, 1'b0, 5'd0, 8'h00);
    drive_b(1'b0, 1'b0, 5'd0, 8'h00);
    bus2.req_a = 1'b0; bus2.we_a = 1'b0; bus2.addr_a = '0; bus2.wdata_a = '0;
    bus2.req_b = 1'b0; bus2.we_b = 1'b0; bus2.addr_b = '0; bus2.wdata_b = '0;

    // reset state
    repeat (3) step();
    chk1("reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    rst1 = 1'b0;
    step();

    // clear sweep, requests raised late in INIT stay pending
    run_init1("init1", 5'd3, 5'd7);

    // RUN vectors: alternation, write/read-back, lone B at half rate
    for (int i = 0; i < 18; i++) begin
      chk1($sformatf("vec%0d", i), tbl[i].ga, tbl[i].gb, tbl[i].wr, tbl[i].rd, tbl[i].ad,
           tbl[i].wd, tbl[i].va, tbl[i].vb, tbl[i].rda, tbl[i].rdb, 1'b1);
      drive_a(tbl[i].ra, tbl[i].wa, tbl[i].aa, tbl[i].da);
      drive_b(tbl[i].rb, tbl[i].wb, tbl[i].ab, tbl[i].db);
      step();
    end

    // read granted, then reset one cycle later: read must be dropped
    chk1("rgnt", 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 8'h00, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b1);
    drive_a(1'b0, 1'b0, 5'd5, 8'h00);
    step();
    rst1 = 1'b1;
    step();
    chk1("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    rst1 = 1'b0;
    step();
    run_init1("init2", 5'd2, 5'd4);

    // pointer was reset: the tie goes to A again
    chk1("tie0", 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    drive_a(1'b0, 1'b0, 5'd2, 8'h00);
    step();
    chk1("tie1", 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    drive_b(1'b0, 1'b0, 5'd4, 8'h00);
    step();
    chk1("tie2", 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    step();
    chk1("tie3", 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);

    // dut2: no clear sweep, read latency 2
    chk("d2.rst_done", 32'(bus2.init_done), 32'd0);
    rst2 = 1'b0;
    step();
    chk("d2.done",  32'(bus2.init_done), 32'd1);
    chk("d2.nowr",  32'(bus2.ram_wr_en), 32'd0);
    bus2.req_b = 1'b1; bus2.we_b = 1'b1; bus2.addr_b = 5'd9; bus2.wdata_b = 8'h3C;
    step();
    chk("d2.gnt_b", 32'(bus2.gnt_b),       32'd1);
    chk("d2.wr",    32'(bus2.ram_wr_en),   32'd1);
    chk("d2.waddr", 32'(bus2.ram_addr),    32'd9);
    chk("d2.wdata", 32'(bus2.ram_wr_data), 32'h3C);
    bus2.req_b = 1'b0;
    bus2.req_a = 1'b1; bus2.we_a = 1'b0; bus2.addr_a = 5'd9;
    step();
    chk("d2.gnt_a", 32'(bus2.gnt_a),     32'd1);
    chk("d2.rd",    32'(bus2.ram_rd_en), 32'd1);
    chk("d2.raddr", 32'(bus2.ram_addr),  32'd9);
    bus2.req_a = 1'b0;
    step();
    chk("d2.rv+1", 32'(bus2.rvalid_a), 32'd0);
    step();
    chk("d2.rv+2", 32'(bus2.rvalid_a), 32'd0);
    step();
    chk("d2.rv+3",  32'(bus2.rvalid_a), 32'd1);
    chk("d2.rdata", 32'(bus2.rdata_a),  32'h3C);
    chk("d2.rvb",   32'(bus2.rvalid_b), 32'd0);
    step();
    chk("d2.rv+4",  32'(bus2.rvalid_a), 32'd0);
    chk("d2.hold",  32'(bus2.rdata_a),  32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
